d_sram_like_bridge: RTL and testbench
=====================================

Name: d_sram_like_bridge

Overview:
- Sits directly downstream of the datapath's MEM-stage data SRAM port (mem_enM/mem_addrM/mem_wenM/mem_wdataM/mem_rdataM).
- Converts that single-cycle SRAM request into a two-phase sram_like bus transaction (req/addr_ok, then data_ok).
- Raises a stall toward the hazard unit until the transaction completes.
- Holds returned read data stable while the pipeline stays frozen for other reasons.

Parameters:
- MAP_KSEG, 1, when 1, bus address = {3'b000, cpu_addr[28:0]} for kseg0/kseg1 (cpu_addr[31:30]==2'b10); other addresses pass unchanged. When 0, no mapping.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_data_en  in  1  MEM-stage access request (mem_enM)
- cpu_data_wen  in  4  byte write enables; 0 = read
- cpu_data_addr  in  32  virtual byte address
- cpu_data_wdata  in  32  write data, already lane-aligned
- cpu_longest_stall  in  1  pipeline held by another source (div, etc.), excludes this block's own stall
- cpu_data_rdata  out  32  read data to datapath (mem_rdataM)
- cpu_data_stall  out  1  stall request to hazard unit
- data_req  out  1  sram_like request
- data_wr  out  1  1 = write
- data_size  out  2  0 = byte, 1 = half, 2 = word
- data_addr  out  32  bus address
- data_wdata  out  32  bus write data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  read data valid / write complete
- data_rdata  in  32  bus read data

Behaviour:
- States: IDLE, ADDR, DATA, DONE. Encoding is implementation choice. Reset returns to IDLE asynchronously.
- Reset values: state = IDLE, rdata_buf = 0, data_req = 0, cpu_data_stall = 0.
- data_req = (IDLE & cpu_data_en) | ADDR.
  - Once asserted, data_req stays high with constant addr/wr/size/wdata until data_addr_ok.
  - Request fields are latched on entry from IDLE and driven from the latch in ADDR.
- data_wr = |cpu_data_wen (latched).
- data_size from wen:
  - 1111 -> 2
  - 0011/1100 -> 1
  - single-hot -> 0
  - read -> 2
  - any other wen pattern is illegal: size 2, no checking.
- data_addr:
  - reads: addr[1:0] forced to 00.
  - writes: full byte address.
  - MAP_KSEG mapping applied to both.
- Transitions:
  - IDLE -> DATA when cpu_data_en & data_addr_ok in the same cycle.
  - IDLE -> ADDR when cpu_data_en & ~data_addr_ok.
  - ADDR -> DATA on data_addr_ok.
  - DATA -> DONE on data_data_ok, capturing rdata_buf <= data_rdata (writes capture too, value ignored).
  - DONE -> IDLE when ~cpu_longest_stall; otherwise remain in DONE.
- data_data_ok is only honoured in DATA. Ignored in IDLE/ADDR/DONE; the bus guarantees data_ok is at least 1 cycle after addr_ok.
- cpu_data_stall = cpu_data_en & (state != DONE). Combinational; high in the same cycle the request is first presented.
- cpu_data_rdata = rdata_buf, stable from DONE entry until the next capture.
- Minimum access latency: addr_ok in the request cycle, data_ok next cycle -> stall 2 cycles, DONE on 3rd.
- DONE with cpu_longest_stall held N cycles: no new req issued, rdata stable, stall low for all N cycles.
- Leaving DONE with cpu_data_en still high (the next instruction is also a memory op): IDLE immediately re-issues on the following cycle. A single access is never replayed, because the pipeline advances in the DONE->IDLE cycle.
- There is no abort: once req is issued, the transaction runs to data_ok even if the instruction is later flushed. Results are discarded by the datapath.
- Async rst mid-transaction: all state cleared and req dropped immediately. Bus-side recovery is the system's responsibility.

Test Plan:
- Read, addr_ok same cycle, data_ok +1, rdata 0xDEADBEEF: stall high 2 cycles, cpu_data_rdata = 0xDEADBEEF in DONE, data_wr = 0, data_size = 2.
- Write sb, wen 0100, addr 0x8000_1002, addr_ok delayed 3 cycles: req held 4 cycles with data_addr = 0x0000_1002 and data_size = 0 constant, stall released only after data_ok.
- Read done while cpu_longest_stall high 5 cycles: no second req, rdata stable, stall low throughout, IDLE after the stall drops.
- Back-to-back lw then sw (cpu_data_en continuously high): exactly two req handshakes, the second starting the cycle after DONE->IDLE.
- Spurious data_data_ok pulse in IDLE/ADDR: ignored, no state change, rdata_buf unchanged.
- rst asserted in DATA: data_req = 0, cpu_data_stall = 0, cpu_data_rdata = 0 before the next clock edge; MAP_KSEG = 0 run: 0xA000_0000 emitted unchanged.

Source files
------------

// File: rtl/d_sram_like_bridge.sv
// d_sram_like_bridge: turns the MEM-stage single-cycle SRAM access into an sram_like req/addr_ok/data_ok transaction
//   clk, rst                     : clock, async active-high reset
//   cpu_data_en/wen/addr/wdata   : MEM-stage request (wen==0 means read)
//   cpu_longest_stall            : pipeline frozen by another source
//   cpu_data_rdata, cpu_data_stall : read data held until next capture, stall to hazard unit
//   data_req/wr/size/addr/wdata  : sram_like request channel
//   data_addr_ok/data_ok/rdata   : sram_like handshakes and read data
module d_sram_like_bridge #(
  parameter bit MAP_KSEG = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_data_en,
  input  logic [3:0]  cpu_data_wen,
  input  logic [31:0] cpu_data_addr,
  input  logic [31:0] cpu_data_wdata,
  input  logic        cpu_longest_stall,
  output logic [31:0] cpu_data_rdata,
  output logic        cpu_data_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
  state_t state, state_n;
  logic [31:0] rdata_buf, addr_q, wdata_q, addr_c, addr_a;
  logic [1:0] size_q, size_c;
  logic wr_q, wr_c, idle;
  assign idle = state == IDLE;
  assign wr_c = |cpu_data_wen;
  always_comb begin
    size_c = (cpu_data_wen == 4'b0011 || cpu_data_wen == 4'b1100) ? 2'd1 :
             (cpu_data_wen == 4'b0001 || cpu_data_wen == 4'b0010 ||
              cpu_data_wen == 4'b0100 || cpu_data_wen == 4'b1000) ? 2'd0 : 2'd2;
    addr_a = wr_c ? cpu_data_addr : {cpu_data_addr[31:2], 2'b00};
    addr_c = (MAP_KSEG && addr_a[31:30] == 2'b10) ? {3'b000, addr_a[28:0]} : addr_a;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = cpu_data_en ? (data_addr_ok ? DATA : ADDR) : IDLE;
      ADDR: state_n = data_addr_ok ? DATA : ADDR;
      DATA: state_n = data_data_ok ? DONE : DATA;
      DONE: state_n = cpu_longest_stall ? DONE : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rdata_buf <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      wr_q      <= 1'b0;
    end else begin
      state <= state_n;
      if (idle && cpu_data_en) begin
        addr_q  <= addr_c;
        wdata_q <= cpu_data_wdata;
        size_q  <= size_c;
        wr_q    <= wr_c;
      end
      if (state == DATA && data_data_ok) rdata_buf <= data_rdata;
    end
  end
  // rst gating drops req/stall in the same cycle reset is raised, not at the next edge
  assign data_req       = ~rst & ((idle & cpu_data_en) | (state == ADDR));
  assign data_wr        = idle ? wr_c : wr_q;
  assign data_size      = idle ? size_c : size_q;
  assign data_addr      = idle ? addr_c : addr_q;
  assign data_wdata     = idle ? cpu_data_wdata : wdata_q;
  assign cpu_data_stall = ~rst & cpu_data_en & (state != DONE);
  assign cpu_data_rdata = rdata_buf;
endmodule

// File: tb/tb_d_sram_like_bridge.sv
module tb_d_sram_like_bridge;
  logic clk = 1'b0, rst = 1'b1;
  logic cpu_data_en = 1'b0, cpu_longest_stall = 1'b0;
  logic [3:0] cpu_data_wen = '0;
  logic [31:0] cpu_data_addr = '0, cpu_data_wdata = '0, data_rdata = '0;
  logic data_addr_ok = 1'b0, data_data_ok = 1'b0;
  logic [31:0] cpu_data_rdata, data_addr, data_wdata;
  logic cpu_data_stall, data_req, data_wr;
  logic [1:0] data_size;
  logic [31:0] rdata1, addr1, wdata1;
  logic stall1, req1, wr1;
  logic [1:0] size1;
  int checks = 0, errors = 0, hs = 0, hs0;

  always #5 clk = ~clk;
  always @(posedge clk) if (data_req && data_addr_ok) hs++;

  d_sram_like_bridge #(.MAP_KSEG(1'b1)) u0 (
    .clk(clk), .rst(rst), .cpu_data_en(cpu_data_en), .cpu_data_wen(cpu_data_wen),
    .cpu_data_addr(cpu_data_addr), .cpu_data_wdata(cpu_data_wdata),
    .cpu_longest_stall(cpu_longest_stall), .cpu_data_rdata(cpu_data_rdata),
    .cpu_data_stall(cpu_data_stall), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata));

  d_sram_like_bridge #(.MAP_KSEG(1'b0)) u1 (
    .clk(clk), .rst(rst), .cpu_data_en(cpu_data_en), .cpu_data_wen(cpu_data_wen),
    .cpu_data_addr(cpu_data_addr), .cpu_data_wdata(cpu_data_wdata),
    .cpu_longest_stall(cpu_longest_stall), .cpu_data_rdata(rdata1),
    .cpu_data_stall(stall1), .data_req(req1), .data_wr(wr1),
    .data_size(size1), .data_addr(addr1), .data_wdata(wdata1),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(); step();
    chk("rst_req", 32'(data_req), 32'd0);
    chk("rst_stall", 32'(cpu_data_stall), 32'd0);
    chk("rst_rdata", cpu_data_rdata, 32'd0);
    rst = 1'b0;
    step();
    // read, addr_ok in request cycle, data_ok next cycle
    cpu_data_en = 1'b1; cpu_data_wen = 4'b0000; cpu_data_addr = 32'h8000_0106; data_addr_ok = 1'b1;
    #1;
    chk("rd_req", 32'(data_req), 32'd1);
    chk("rd_wr", 32'(data_wr), 32'd0);
    chk("rd_size", 32'(data_size), 32'd2);
    chk("rd_addr", data_addr, 32'h0000_0104);
    chk("rd_stall1", 32'(cpu_data_stall), 32'd1);
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rd_req_data", 32'(data_req), 32'd0);
    chk("rd_stall2", 32'(cpu_data_stall), 32'd1);
    step();
    data_data_ok = 1'b0;
    chk("rd_stall_done", 32'(cpu_data_stall), 32'd0);
    chk("rd_rdata", cpu_data_rdata, 32'hDEAD_BEEF);
    cpu_data_en = 1'b0;
    step();
    chk("rd_idle_req", 32'(data_req), 32'd0);
    // sb with addr_ok delayed 3 cycles; cpu inputs disturbed to prove latching
    cpu_data_en = 1'b1; cpu_data_wen = 4'b0100; cpu_data_addr = 32'h8000_1002; cpu_data_wdata = 32'h00AB_0000;
    #1;
    chk("sb_req0", 32'(data_req), 32'd1);
    chk("sb_addr0", data_addr, 32'h0000_1002);
    chk("sb_size0", 32'(data_size), 32'd0);
    chk("sb_wr0", 32'(data_wr), 32'd1);
    chk("sb_wdata0", data_wdata, 32'h00AB_0000);
    step();
    cpu_data_addr = 32'h1234_5678; cpu_data_wen = 4'b1111; cpu_data_wdata = 32'h0;
    for (int i = 1; i < 4; i++) begin
      if (i == 3) data_addr_ok = 1'b1;
      #1;
      chk($sformatf("sb_req%0d", i), 32'(data_req), 32'd1);
      chk($sformatf("sb_addr%0d", i), data_addr, 32'h0000_1002);
      chk($sformatf("sb_size%0d", i), 32'(data_size), 32'd0);
      chk($sformatf("sb_wdata%0d", i), data_wdata, 32'h00AB_0000);
      chk($sformatf("sb_stall%0d", i), 32'(cpu_data_stall), 32'd1);
      step();
    end
    data_addr_ok = 1'b0;
    chk("sb_req_data", 32'(data_req), 32'd0);
    chk("sb_stall_data", 32'(cpu_data_stall), 32'd1);
    step();
    data_data_ok = 1'b1; data_rdata = 32'h1111_1111;
    #1;
    chk("sb_stall_dok", 32'(cpu_data_stall), 32'd1);
    step();
    data_data_ok = 1'b0;
    chk("sb_stall_done", 32'(cpu_data_stall), 32'd0);
    chk("sb_rdata_cap", cpu_data_rdata, 32'h1111_1111);
    cpu_data_en = 1'b0;
    step();
    // read completing while pipeline held 5 cycles
    hs0 = hs;
    cpu_data_en = 1'b1; cpu_data_wen = 4'b0000; cpu_data_addr = 32'h0000_0200; data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
    step();
    data_data_ok = 1'b0; cpu_longest_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("hold_req%0d", i), 32'(data_req), 32'd0);
      chk($sformatf("hold_stall%0d", i), 32'(cpu_data_stall), 32'd0);
      chk($sformatf("hold_rdata%0d", i), cpu_data_rdata, 32'hCAFE_F00D);
      if (i == 4) begin cpu_longest_stall = 1'b0; cpu_data_en = 1'b0; end
      step();
    end
    chk("hold_hs", 32'(hs - hs0), 32'd1);
    // spurious data_ok in IDLE then in ADDR
    data_data_ok = 1'b1; data_rdata = 32'h9999_9999;
    step();
    chk("sp_idle_rdata", cpu_data_rdata, 32'hCAFE_F00D);
    chk("sp_idle_req", 32'(data_req), 32'd0);
    cpu_data_en = 1'b1; cpu_data_addr = 32'h0000_0300;
    step();
    step();
    chk("sp_addr_req", 32'(data_req), 32'd1);
    chk("sp_addr_stall", 32'(cpu_data_stall), 32'd1);
    chk("sp_addr_rdata", cpu_data_rdata, 32'hCAFE_F00D);
    chk("sp_addr_addr", data_addr, 32'h0000_0300);
    data_data_ok = 1'b0; data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0BAD_F00D;
    step();
    data_data_ok = 1'b0;
    chk("sp_fin_rdata", cpu_data_rdata, 32'h0BAD_F00D);
    cpu_data_en = 1'b0;
    step();
    // back-to-back lw then sw
    hs0 = hs;
    cpu_data_en = 1'b1; cpu_data_wen = 4'b0000; cpu_data_addr = 32'h0000_0400; data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
    step();
    data_data_ok = 1'b0;
    chk("b2b_done_req", 32'(data_req), 32'd0);
    chk("b2b_done_stall", 32'(cpu_data_stall), 32'd0);
    chk("b2b_lw_rdata", cpu_data_rdata, 32'h1234_5678);
    step();
    cpu_data_wen = 4'b1111; cpu_data_addr = 32'h0000_0500; cpu_data_wdata = 32'hA5A5_A5A5;
    #1;
    chk("b2b_sw_req", 32'(data_req), 32'd1);
    chk("b2b_sw_wr", 32'(data_wr), 32'd1);
    chk("b2b_sw_size", 32'(data_size), 32'd2);
    chk("b2b_sw_addr", data_addr, 32'h0000_0500);
    chk("b2b_sw_stall", 32'(cpu_data_stall), 32'd1);
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h7777_7777;
    step();
    data_data_ok = 1'b0;
    chk("b2b_sw_stall_done", 32'(cpu_data_stall), 32'd0);
    chk("b2b_sw_rdata", cpu_data_rdata, 32'h7777_7777);
    chk("b2b_hs", 32'(hs - hs0), 32'd2);
    cpu_data_en = 1'b0;
    step();
    // async reset while in DATA
    cpu_data_en = 1'b1; cpu_data_wen = 4'b0000; cpu_data_addr = 32'h0000_0600; data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0;
    chk("rstd_stall_pre", 32'(cpu_data_stall), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rstd_req", 32'(data_req), 32'd0);
    chk("rstd_stall", 32'(cpu_data_stall), 32'd0);
    chk("rstd_rdata", cpu_data_rdata, 32'd0);
    step();
    rst = 1'b0; cpu_data_en = 1'b0;
    step();
    // kseg mapping on vs off, halfword write
    cpu_data_en = 1'b1; cpu_data_wen = 4'b1100; cpu_data_addr = 32'hA000_0002;
    #1;
    chk("map1_addr", data_addr, 32'h0000_0002);
    chk("map1_size", 32'(data_size), 32'd1);
    chk("map0_addr", addr1, 32'hA000_0002);
    cpu_data_wen = 4'b0000; cpu_data_addr = 32'hA000_0000;
    #1;
    chk("map0_rd_addr", addr1, 32'hA000_0000);
    chk("map1_rd_addr", data_addr, 32'h0000_0000);
    rst = 1'b1;
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
